alu_arbiter: RTL

- Shares one combinational 8-bit `alu` instance between NREQ requesters.
- Each requester presents an opcode/a/b triple with a valid/ready handshake. A round-robin scheduler grants one request at a time.
- The block registers the operands, drives the shared ALU, captures the result and returns it on a single response channel tagged with the requester id.
- Sits between the block's clients and the ALU datapath. It is the only driver of the ALU's opcode, a and b inputs.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu.sv | 26 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: operand width, ALU opcodes
// and the arbiter state encoding.
package alu_pkg;

  localparam int DW = 8;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOTA = 3'd5;
  localparam logic [2:0] ALU_SHL  = 3'd6;
  localparam logic [2:0] ALU_SHR  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the clients and the ALU arbiter.
// Requester i occupies slice i of each packed request field.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_opcode;
  logic [DW*NREQ-1:0] req_a;
  logic [DW*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu.sv
// Shared combinational 8-bit ALU. Shift amounts use the low three bits of b.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOTA: result = ~a;
      ALU_SHL:  result = a << b[2:0];
      ALU_SHR:  result = a >> b[2:0];
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or above i_ptr,
// wrapping modulo NREQ, wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_rot_idx [NREQ];

  // w_rot_idx[k] is the requester index sitting k places after the pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDW:0] w_sum;
    assign w_sum = {1'b0, i_ptr} + (IDW+1)'(gi);
    assign w_rot_idx[gi] = (w_sum >= (IDW+1)'(NREQ)) ?
                           IDW'(w_sum - (IDW+1)'(NREQ)) : w_sum[IDW-1:0];
  end

  assign o_any = |i_req;

  // Scan from the farthest position down so the nearest request wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[w_rot_idx[k]]) begin
        o_grant                = '0;
        o_grant[w_rot_idx[k]]  = 1'b1;
        o_grant_idx            = w_rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one combinational ALU between NREQ requesters: grant, register
// operands, execute, then hold the tagged result until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic [15:0]   op_count
);

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic [2:0]      r_opcode;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [DW-1:0]   r_rsp_data;
  logic [15:0]     r_op_count;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_idx;
  logic            w_any;
  logic            w_idle;
  logic            w_accept;
  logic [IDW-1:0]  w_next_ptr;
  logic [2:0]      w_sel_opcode;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic [DW-1:0]   w_alu_result;

  logic [2:0]      w_opc [NREQ];
  logic [DW-1:0]   w_a   [NREQ];
  logic [DW-1:0]   w_b   [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_opc[gi] = bus.req_opcode[3*gi +: 3];
    assign w_a[gi]   = bus.req_a[DW*gi +: DW];
    assign w_b[gi]   = bus.req_b[DW*gi +: DW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_req       (bus.req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // One-hot grant makes an OR-style select safe.
  always_comb begin
    w_sel_opcode = '0;
    w_sel_a      = '0;
    w_sel_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_opcode = w_opc[i];
        w_sel_a      = w_a[i];
        w_sel_b      = w_b[i];
      end
    end
  end

  // Ready is suppressed while reset is held so nothing looks accepted.
  assign w_idle        = (r_state == ST_IDLE) && rst_n;
  assign w_accept      = w_idle && w_any;
  assign bus.req_ready = w_idle ? w_grant : '0;
  assign w_next_ptr    = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

  alu u_alu (
    .opcode (r_opcode),
    .a      (r_a),
    .b      (r_b),
    .result (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_opcode    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opcode <= w_sel_opcode;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_alu_result;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign busy          = (r_state != ST_IDLE);
  assign op_count      = r_op_count;

endmodule
